// File: rtl/iiitb_sq_pkg.sv
// Shared marker definitions for the 1010 frame transmitter and detector.
// TX and RX import the same marker so the two ends cannot drift apart.
package iiitb_sq_pkg;

  localparam int             MARKER_LEN = 4;
  localparam logic [3:0]     MARKER     = 4'b1010;
  // A marker prefix in the line history forces a stuff bit on the next data slot.
  localparam logic [2:0]     STUFF_HIST = MARKER[3:1];

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_MARK,
    TX_DATA,
    TX_TAIL,
    TX_GAP
  } tx_state_t;

  // Detector states: S<n> = n marker bits matched so far.
  typedef enum logic [1:0] {
    S0,
    S1,
    S2,
    S3
  } rx_state_t;

endpackage

// File: rtl/iiitb_sqg_1010_if.sv
// Payload handshake and serial line bundle for the 1010 frame transmitter.
interface iiitb_sqg_1010_if #(parameter int WIDTH = 8);
  logic             tick;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             dout;
  logic             busy;
  logic             stuffed;

  modport master (output tick, in_valid, in_data,
                  input  in_ready, dout, busy, stuffed);
  modport slave  (input  tick, in_valid, in_data,
                  output in_ready, dout, busy, stuffed);
endinterface

// File: rtl/iiitb_sqg_stuffer.sv
// Line history tracker: remembers the last three emitted bits and decides when
// a stuff bit is needed so 1010 never forms outside a marker.
module iiitb_sqg_stuffer
  import iiitb_sq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic adv,
  input  logic bit_in,
  output logic stuff_req,
  output logic tail_req
);

  logic [2:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   hist <= 3'b000;
    else if (adv) hist <= {hist[1:0], bit_in};
  end

  assign stuff_req = (hist == STUFF_HIST);
  // Looks one bit ahead: a payload ending in 101 would meet the idle zeros.
  assign tail_req  = ({hist[1:0], bit_in} == STUFF_HIST);

endmodule

// File: rtl/iiitb_sqg_1010.sv
// Serial frame transmitter: 1010 marker, bit-stuffed MSB-first payload, zero gap.
module iiitb_sqg_1010
  import iiitb_sq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 4
)(
  input  logic           clk,
  input  logic           reset,
  iiitb_sqg_1010_if.slave bus
);

  localparam int MAXC = (WIDTH > GAP) ? ((WIDTH > MARKER_LEN) ? WIDTH : MARKER_LEN)
                                      : ((GAP   > MARKER_LEN) ? GAP   : MARKER_LEN);
  localparam int CW   = $clog2(MAXC + 1);

  tx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             dout_q, busy_q, stuffed_q;
  logic             emit, emit_bit, stuff_req, tail_req;
  logic [1:0]       midx;

  assign midx = 2'(MARKER_LEN - 1) - cnt[1:0];

  always_comb begin
    emit     = 1'b0;
    emit_bit = 1'b0;
    case (state)
      TX_MARK: begin emit = bus.tick; emit_bit = MARKER[midx]; end
      TX_DATA: begin emit = bus.tick; emit_bit = stuff_req ? 1'b1 : shreg[WIDTH-1]; end
      TX_TAIL: begin emit = bus.tick; emit_bit = 1'b1; end
      TX_GAP:  begin emit = bus.tick; emit_bit = 1'b0; end
      default: ;
    endcase
  end

  iiitb_sqg_stuffer u_stuffer (
    .clk       (clk),
    .reset     (reset),
    .adv       (emit),
    .bit_in    (emit_bit),
    .stuff_req (stuff_req),
    .tail_req  (tail_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      stuffed_q <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          dout_q    <= 1'b0;
          stuffed_q <= 1'b0;
          // Capture is tick-independent; emission waits for the next tick.
          if (bus.in_valid) begin
            shreg  <= bus.in_data;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= TX_MARK;
          end
        end
        TX_MARK: if (bus.tick) begin
          dout_q    <= emit_bit;
          stuffed_q <= 1'b0;
          if (cnt == CW'(MARKER_LEN - 1)) begin
            cnt   <= '0;
            state <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: if (bus.tick) begin
          dout_q    <= emit_bit;
          stuffed_q <= stuff_req;
          if (!stuff_req) begin
            shreg <= shreg << 1;
            if (cnt == CW'(WIDTH - 1)) begin
              cnt   <= '0;
              state <= tail_req ? TX_TAIL : TX_GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        TX_TAIL: if (bus.tick) begin
          dout_q    <= 1'b1;
          stuffed_q <= 1'b1;
          cnt       <= '0;
          state     <= TX_GAP;
        end
        TX_GAP: if (bus.tick) begin
          dout_q    <= 1'b0;
          stuffed_q <= 1'b0;
          if (cnt == CW'(GAP - 1)) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == TX_IDLE) && reset;
  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.stuffed  = stuffed_q;

endmodule

// File: tb/tb_iiitb_sqg_1010.sv
// Scoreboard bench for the 1010 frame transmitter: directed frames, expected
// bit/stuff pairs queued at issue time, popped by a monitor on every emitted bit.
module tb_iiitb_sqg_1010;

  localparam int WIDTH = 8;
  localparam int GAP   = 4;

  typedef struct packed { logic d; logic s; } bit_t;

  logic clk = 1'b0;
  logic reset;
  iiitb_sqg_1010_if #(.WIDTH(WIDTH)) bus();

  iiitb_sqg_1010 #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  int   tmode = 0, cyc = 0, markers = 0;
  bit_t exp_q[$];
  bit_t e;
  logic [3:0] det = 4'b0000;
  logic pb = 1'b0, pt = 1'b0, pd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bits listed first-on-line first: bit [len-1] is the first emitted.
  task automatic push_frame(input logic [31:0] bits, input logic [31:0] smask, input int len);
    for (int i = len - 1; i >= 0; i--) exp_q.push_back('{d: bits[i], s: smask[i]});
  endtask

  // Bit-rate enable: every cycle, or one cycle in three.
  initial begin
    bus.tick = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.tick = (tmode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // An edge emits a bit exactly when busy was high and tick was high before it.
  always @(negedge clk) begin
    if (!reset) begin
      pb = 1'b0;
    end else begin
      if (pb && pt) begin
        if (exp_q.size() == 0) chk("no_expected_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dout", bus.dout, e.d);
          chk("stuffed", bus.stuffed, e.s);
        end
        det = {det[2:0], bus.dout};
        if (det == 4'b1010) markers++;
      end else if (pb) begin
        chk("hold_dout", bus.dout, pd);
      end
      pb = bus.busy;
      pt = bus.tick;
      pd = bus.dout;
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    @(posedge clk); #2;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 3000) begin @(negedge clk); #1; t++; end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, t;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stuffed", bus.stuffed, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.in_ready, 1);

    // 0x00: plain frame, no stuffing, 16 busy cycles
    push_frame(32'b1010_0000_0000_0000, 32'b0, 16);
    send(8'h00, 1'b0);
    bc = 0;
    @(negedge clk);
    while (bus.busy && bc < 100) begin bc++; @(negedge clk); end
    chk("busy_cycles_00", bc, 16);
    chk("ready_after_gap", bus.in_ready, 1);
    drain();

    // 0xA5: two data stuffs plus a tail stuff
    push_frame(32'b1010_1101_1001_0110_000, 32'b0000_0100_1000_0010_000, 19);
    send(8'hA5, 1'b0);
    drain();

    // 0xFF: one stuff, no tail
    push_frame(32'b1010_1111_1111_1_0000, 32'b0000_0100_0000_0_0000, 17);
    send(8'hFF, 1'b0);
    drain();

    // Back-to-back 0xA5, 0x55 with in_valid held; in_data changes after capture
    markers = 0;
    push_frame(32'b1010_1101_1001_0110_000, 32'b0000_0100_1000_0010_000, 19);
    send(8'hA5, 1'b1);
    bus.in_data = 8'h55;
    push_frame(32'b1010_0101_1011_0110_000, 32'b0000_0000_1001_0010_000, 19);
    send(8'h55, 1'b0);
    drain();
    chk("marker_count", markers, 2);

    // Slow tick: same bits, each held across the idle ticks
    tmode = 1;
    push_frame(32'b1010_1101_1001_0110_000, 32'b0000_0100_1000_0010_000, 19);
    send(8'hA5, 1'b0);
    drain();
    tmode = 0;

    // Reset during the 6th data bit of 0xFF
    push_frame(32'b1010_1111_111, 32'b0000_0100_000, 11);
    send(8'hFF, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); #1; t++; end
    chk("abort_prefix", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    chk("abort_dout", bus.dout, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_stuffed", bus.stuffed, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", bus.in_ready, 1);
    push_frame(32'b1010_0000_0000_0000, 32'b0, 16);
    send(8'h00, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iiitb_sqg_1010.md
Name: iiitb_sqg_1010

Overview:
- Serial frame transmitter; the transmit-side counterpart of the team's 1010 sequence detector.
- Accepts a parallel payload word over a valid/ready handshake and emits one frame per word on a 1-bit line:
  - start marker 1010;
  - payload MSB-first with bit stuffing;
  - an idle gap of zeros.
- Stuffing guarantees that 1010 appears on dout only as a frame marker, so a downstream 1010 detector fires exactly once per frame.

Parameters:
- WIDTH, 8, payload bits per frame (>=1).
- GAP, 4, minimum zero bits between frames (>=3, so history is 000 before the next marker).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tick  input  1  bit-rate enable; dout advances one bit on each clk edge with tick=1.
- in_valid  input  1  payload word offered.
- in_data  input  WIDTH  payload word; captured on handshake.
- in_ready  output  1  block can accept a word.
- dout  output  1  registered serial line; idles at 0.
- busy  output  1  high from handshake until the gap completes.
- stuffed  output  1  registered; high while dout carries a stuff bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, dout=0, busy=0, stuffed=0, in_ready=0 while asserted.
  - hist=000, counters cleared, shift register cleared.
  - Reset mid-frame aborts the frame immediately; dout drops to 0 with no trailing bits.
- in_ready = (state==IDLE) and reset deasserted.
- Handshake: in_valid & in_ready on a clk edge captures in_data into the shift register, sets busy, and moves to MARK. tick is ignored for the capture.
- All bit emission happens only on edges with tick=1. With tick held at 1, the first marker bit appears on dout one cycle after the handshake edge.
- hist is a 3-bit register holding the last three bits placed on dout, newest in bit 0. It updates with every emitted bit, including marker, stuff and gap bits.
- MARK: emits 1,0,1,0 on four ticks, then moves to DATA.
- DATA, on each tick:
  - if hist==101: emit stuff bit 1, stuffed=1, data bit not consumed;
  - else: emit the shift-register MSB, shift left, bit counter +1, stuffed=0.
  - After the WIDTH-th data bit:
    - if hist (including that bit) == 101, go to TAIL;
    - else go to GAP.
- TAIL: emits one trailing stuff 1 (stuffed=1), then moves to GAP. This prevents idle zeros from completing a 1010.
- GAP: emits GAP zeros, then moves to IDLE and clears busy. in_ready rises on the edge where GAP completes, so back-to-back frames always keep at least GAP zeros between them.
- IDLE: dout=0, stuffed=0.
- Frame length: 4 + WIDTH + stuff count (+1 for TAIL) + GAP ticks. Maximum stuff count is ceil(WIDTH/2), for an alternating payload.
- tick=0: all state, hist and outputs hold.
- in_valid during busy: ignored (in_ready=0); the word is not captured.
- in_data may change after the handshake without effect.
- Invariant: across any sequence of frames, the pattern 1010 on dout starts only at marker positions.

Decomposition:
- Shared package iiitb_sq_pkg:
  - state encoding IDLE/MARK/DATA/TAIL/GAP;
  - MARKER=4'b1010, MARKER_LEN=4.
  - The existing detector's S0..S3 codes move here too, so TX and RX share the marker definition.
- One natural sub-module: iiitb_sqg_stuffer. It owns hist, the 101 check and the stuff decision, and is reusable by a future destuffing receiver.

Test Plan:
- WIDTH=8, tick=1, in_data=0x00 -> dout 1010 00000000 0000; stuffed never high; busy for 16 cycles; in_ready returns on cycle 17.
- in_data=0xA5 -> dout 1010 1 [1] 0 1 [1] 0 0 1 0 1 [1] 0000. stuffed high on exactly the three bracketed bits (the last is TAIL); 19 bits total.
- in_data=0xFF -> dout 1010 1 [1] 1111111 0000. Exactly one stuff bit; no TAIL, since the final hist is 111.
- Back-to-back 0xA5 then 0x55 with in_valid held high:
  - second marker starts after exactly 4 gap zeros;
  - a reference 1010 detector fed dout fires exactly twice, once per marker.
- tick pulsed every 3rd cycle with 0xA5 -> same bit sequence as the tick=1 case; each bit held 3 cycles.
- reset driven low during the 6th data bit of 0xFF:
  - dout=0, busy=0, stuffed=0 immediately, without waiting for clk;
  - after release, in_ready=1 and a new 0x00 frame is emitted cleanly.
